// File: rtl/matmul_scheduler.sv
// Sequencer for an HxC by CxW single-precision matrix product that time-shares
// one external multiplier and one external adder, accumulating each dot product internally.
module matmul_scheduler #(
    parameter int S   = 32,
    parameter int H   = 2,
    parameter int W   = 2,
    parameter int C   = 2,
    parameter int AW  = 8,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    input  logic [S-1:0]  a_data,
    input  logic [S-1:0]  b_data,
    output logic          mul_start,
    output logic [S-1:0]  mul_x,
    output logic [S-1:0]  mul_y,
    input  logic          mul_done,
    input  logic [S-1:0]  mul_result,
    output logic          add_start,
    output logic [S-1:0]  add_x,
    output logic [S-1:0]  add_y,
    input  logic          add_done,
    input  logic [S-1:0]  add_result,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [S-1:0]  o_data
);

    localparam int IW = (H > 1) ? $clog2(H) : 1;
    localparam int JW = (W > 1) ? $clog2(W) : 1;
    localparam int KW = (C > 1) ? $clog2(C) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(H - 1);
    localparam logic [JW-1:0] J_LAST = JW'(W - 1);
    localparam logic [KW-1:0] K_LAST = KW'(C - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, MUL, MWAIT, ADD, AWAIT, WRITE, DONE, ERR
    } state_t;

    state_t        state_r;
    logic [IW-1:0] i_r;
    logic [JW-1:0] j_r;
    logic [KW-1:0] k_r;
    logic [TW-1:0] wait_r;
    logic [S-1:0]  acc_r;

    logic [IW-1:0] i_nxt_s;
    logic [JW-1:0] j_nxt_s;
    logic [KW-1:0] k_inc_s;
    logic          k_last_s;
    logic          last_elem_s;

    // Row-major linear index: row * stride + col.
    function automatic logic [AW-1:0] lin_idx(input logic [AW-1:0] row,
                                              input logic [AW-1:0] stride,
                                              input logic [AW-1:0] col);
        return row * stride + col;
    endfunction

    // Loop-counter successors for the k step and the j/i element advance.
    always_comb begin
        k_inc_s     = k_r + KW'(1);
        k_last_s    = (k_r == K_LAST);
        last_elem_s = (i_r == I_LAST) && (j_r == J_LAST);
        if (j_r == J_LAST) begin
            j_nxt_s = {JW{1'b0}};
            i_nxt_s = i_r + IW'(1);
        end else begin
            j_nxt_s = j_r + JW'(1);
            i_nxt_s = i_r;
        end
    end

    // Control FSM with all outputs registered; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            i_r       <= {IW{1'b0}};
            j_r       <= {JW{1'b0}};
            k_r       <= {KW{1'b0}};
            wait_r    <= {TW{1'b0}};
            acc_r     <= {S{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            a_addr    <= {AW{1'b0}};
            b_addr    <= {AW{1'b0}};
            mul_start <= 1'b0;
            mul_x     <= {S{1'b0}};
            mul_y     <= {S{1'b0}};
            add_start <= 1'b0;
            add_x     <= {S{1'b0}};
            add_y     <= {S{1'b0}};
            o_we      <= 1'b0;
            o_addr    <= {AW{1'b0}};
            o_data    <= {S{1'b0}};
        end else begin
            mul_start <= 1'b0;
            add_start <= 1'b0;
            o_we      <= 1'b0;
            done      <= 1'b0;
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_r <= FETCH;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        i_r     <= {IW{1'b0}};
                        j_r     <= {JW{1'b0}};
                        k_r     <= {KW{1'b0}};
                        acc_r   <= {S{1'b0}};
                        a_addr  <= {AW{1'b0}};
                        b_addr  <= {AW{1'b0}};
                    end
                end
                FETCH: begin
                    mul_x     <= a_data;
                    mul_y     <= b_data;
                    mul_start <= 1'b1;
                    state_r   <= MUL;
                end
                MUL: begin
                    wait_r  <= {TW{1'b0}};
                    state_r <= MWAIT;
                end
                MWAIT: begin
                    if (mul_done) begin
                        if (k_r != {KW{1'b0}}) begin
                            add_x     <= acc_r;
                            add_y     <= mul_result;
                            add_start <= 1'b1;
                            state_r   <= ADD;
                        end else begin
                            // First partial product seeds the accumulator directly.
                            acc_r <= mul_result;
                            if (k_last_s) begin
                                o_we    <= 1'b1;
                                o_addr  <= lin_idx(AW'(i_r), AW'(W), AW'(j_r));
                                o_data  <= mul_result;
                                state_r <= WRITE;
                            end else begin
                                k_r     <= k_inc_s;
                                a_addr  <= lin_idx(AW'(i_r), AW'(C), AW'(k_inc_s));
                                b_addr  <= lin_idx(AW'(k_inc_s), AW'(W), AW'(j_r));
                                state_r <= FETCH;
                            end
                        end
                    end else if (wait_r == T_LAST) begin
                        state_r <= ERR;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        wait_r <= wait_r + TW'(1);
                    end
                end
                ADD: begin
                    wait_r  <= {TW{1'b0}};
                    state_r <= AWAIT;
                end
                AWAIT: begin
                    if (add_done) begin
                        acc_r <= add_result;
                        if (k_last_s) begin
                            o_we    <= 1'b1;
                            o_addr  <= lin_idx(AW'(i_r), AW'(W), AW'(j_r));
                            o_data  <= add_result;
                            state_r <= WRITE;
                        end else begin
                            k_r     <= k_inc_s;
                            a_addr  <= lin_idx(AW'(i_r), AW'(C), AW'(k_inc_s));
                            b_addr  <= lin_idx(AW'(k_inc_s), AW'(W), AW'(j_r));
                            state_r <= FETCH;
                        end
                    end else if (wait_r == T_LAST) begin
                        state_r <= ERR;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        wait_r <= wait_r + TW'(1);
                    end
                end
                WRITE: begin
                    k_r <= {KW{1'b0}};
                    i_r <= i_nxt_s;
                    j_r <= j_nxt_s;
                    if (last_elem_s) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        a_addr  <= lin_idx(AW'(i_nxt_s), AW'(C), {AW{1'b0}});
                        b_addr  <= lin_idx({AW{1'b0}}, AW'(W), AW'(j_nxt_s));
                        state_r <= FETCH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/matmul_scheduler.md
# matmul_scheduler

Sequencing controller that computes an H×C by C×W single-precision matrix product by time-sharing one external `mul_float` and one external `add_float` unit instead of instantiating H·W·C multipliers. It generates operand read addresses into the A and B operand stores, issues start pulses to the arithmetic units, holds the running dot-product in an internal accumulator, and writes each finished element to the output store. It sits between the layer sequencer, which drives start/done, and the shared float units.

## Interface
- S, 32, float word width
- H, 2, rows of A and O
- W, 2, columns of B and O
- C, 2, common dimension (≥1)
- AW, 8, address width of all three stores (≥ clog2 of max(H·C, C·W, H·W))
- TMO, 255, max cycles to wait for any unit done before faulting
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a product; honored only in IDLE, DONE or ERR
- busy  out  1  high from the cycle after an accepted start until done/err
- done  out  1  one-cycle pulse when the last element is written
- err  out  1  sticky timeout flag; cleared by rst_n or accepted start
- a_addr / b_addr  out  AW  row-major: A index i·C+k, B index k·W+j
- a_data / b_data  in  S  combinational read data for the current address
- mul_start  out  1  one-cycle pulse; mul_x/mul_y valid during the pulse and held until mul_done
- mul_x, mul_y  out  S  multiplier operands
- mul_done  in  1  level; result valid while high
- mul_result  in  S  product
- add_start, add_x, add_y, add_done, add_result: same contract as mul_*, where add_x = accumulator and add_y = product
- o_we  out  1  one-cycle write strobe
- o_addr  out  AW  i·W+j
- o_data  out  S  element value

## Operation
- States: IDLE, FETCH, MUL, MWAIT, ADD, AWAIT, WRITE, DONE, ERR.
- Loop order: i outer, j middle, k inner. Counters are reset to 0 on an accepted start.
- IDLE/DONE/ERR + start → FETCH. Counters i=j=k=0, acc=0, err cleared.
- FETCH: drive a_addr/b_addr, then latch a_data/b_data into the operand registers → MUL.
- MUL: mul_start=1 for one cycle → MWAIT.
- MWAIT: on mul_done, latch prod=mul_result.
  - k==0: acc←prod, skipping the adder.
  - k>0: go to ADD.
  - After the k==0 update: if k==C−1 → WRITE, else k++ and → FETCH.
- ADD: add_start=1 for one cycle with add_x=acc, add_y=prod → AWAIT.
- AWAIT: on add_done, acc←add_result. If k==C−1 → WRITE, else k++ and → FETCH.
- WRITE: o_we=1, o_addr=i·W+j, o_data=acc. k←0 and advance j; when j wraps, j←0 and i++.
  - If the last element was just written (i==H−1, j==W−1) → DONE with a done pulse.
  - Otherwise → FETCH.
- DONE: busy=0. Stays until start.
- Timeout: a wait counter clears on entry to MWAIT/AWAIT and increments each waiting cycle. On reaching TMO: → ERR, err=1, busy=0, no further writes. ERR is left only by start or reset.
- Done inputs are ignored in MUL, ADD and every other state except their own wait state.
- start while busy is ignored and has no side effects.
- C==1: ADD/AWAIT are never entered and no add_start is ever issued.
- NaN/overflow from the units is not inspected; values pass through unchanged.

## Timing
- Reset: all outputs 0 (busy, done, err, mul_start, add_start, o_we, addresses, operand and data buses); state IDLE; acc=0.
- Reset mid-operation: next cycle is IDLE, all outputs 0, no o_we, even if a unit done arrives in the same cycle.
- Accepted start at edge t: FETCH in cycle t+1, busy=1 from t+1, mul_start in cycle t+2.
- With mul latency Lm (cycles from mul_start to first done=1) and add latency La:
  - cycles per k-step: 1 (FETCH) + 1 (MUL) + Lm for k==0; plus 1 (ADD) + La for k>0.
  - one WRITE cycle per element.
- done asserts in the cycle after the final WRITE; busy drops in that same cycle.
- o_we is never asserted twice for the same address within one product.

## Test plan
- H=W=C=2, A=[1,2;3,4] (3F800000,40000000,40400000,40800000), B=[5,6;7,8] (40A00000,40C00000,40E00000,41000000) → writes in order: addr0=41980000, addr1=41B00000, addr2=422C0000, addr3=42480000; then one done pulse.
- C=1, H=W=1, A=40000000, B=40400000 → add_start never asserted; one write of addr0=40C00000; done.
- Unit model with mul latency 5 and add latency 3 on the 2×2 case → results identical; total cycles from start to done match the formula above.
- mul_done held 0 with TMO=10 → err=1 after 10 waiting cycles, busy=0, no o_we. A later start clears err and completes normally.
- rst_n=0 in the middle of the second element → next cycle all outputs 0. A fresh start then produces four writes beginning at addr0.
- start pulsed while busy, and a spurious mul_done during FETCH → neither affects addresses, results or the cycle count.
